load_store_unit: RTL

- Memory-side counterpart of the register file's load/store ports.
- Takes store data from the register file's memory_out and drives it to data memory.
- Fetches load data from data memory and returns it to the register file as a write-back (load_on / address_mem / write_data_mem).
- Gates every access with a key check against the register file's key_access value. Handles alignment, handshake, timeout and faults.

---
 rtl/lsu_defs.sv | 29 ++
 rtl/lsu_timeout_counter.sv | 42 ++++
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit.
//   lsu_state_e   : controller states (3-bit encoding, fixed values)
//   lsu_fault_e   : fault cause codes reported on fault_cause
//   LSU_KEY_W     : default access-key width
//   LSU_ADDR_W    : default data-memory byte-address width
//   LSU_TIMEOUT   : default acknowledge timeout in cycles
package lsu_defs;

  localparam int LSU_KEY_W   = 16;
  localparam int LSU_ADDR_W  = 32;
  localparam int LSU_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_KEY     = 2'd1,
    FC_ALIGN   = 2'd2,
    FC_TIMEOUT = 2'd3
  } lsu_fault_e;

endpackage

// File: rtl/lsu_timeout_counter.sv
// Counts memory-request cycles that pass without an acknowledge.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count back to zero (used whenever no request is pending)
//   enable   : count this cycle (request pending, no ack)
//   expired  : current cycle is the last one allowed before a timeout fault
module lsu_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      // Saturate at the limit; the controller leaves REQ at that point anyway.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the register file and data memory.
// Each accepted request is key-checked and alignment-checked, then issued to
// memory with a req/ack handshake guarded by a timeout. Loads return their data
// to the register file through a one-cycle write-back strobe.
//   req_valid/req_ready/req_*      : request from the core (accepted in IDLE)
//   store_data, key_access         : store word and reference key from the register file
//   mem_req/we/addr/wdata, mem_ack/rdata : data-memory handshake
//   load_on/address_mem/write_data_mem   : register-file load write-back
//   done/fault                     : one-cycle completion / abort pulses
//   fault_cause                    : cause of the most recent fault (held)
module load_store_unit
  import lsu_defs::*;
#(
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int TIMEOUT = LSU_TIMEOUT,
  parameter int KEY_W   = LSU_KEY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [4:0]        req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [KEY_W-1:0]  req_key,
  input  logic [31:0]       store_data,
  input  logic [KEY_W-1:0]  key_access,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              load_on,
  output logic [4:0]        address_mem,
  output logic [31:0]       write_data_mem,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  lsu_state_e state_q, state_d;
  lsu_fault_e fault_cause_q, fault_cause_d;

  // Captured request
  logic              is_store_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [KEY_W-1:0]  key_q;
  logic [31:0]       sdata_q;

  // Registered memory and write-back outputs
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [4:0]        address_mem_q;
  logic [31:0]       write_data_mem_q;

  logic tmo_expired;
  logic accept;
  logic issue;
  logic load_ack;

  lsu_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != ST_REQ),
    .enable  ((state_q == ST_REQ) && !mem_ack),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    fault_cause_d = fault_cause_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        // Key mismatch outranks misalignment.
        if (key_q != key_access) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_KEY;
        end else if (addr_q[1:0] != 2'b00) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_ALIGN;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // An ack on the final allowed cycle still completes the access.
        if (mem_ack) begin
          state_d = is_store_q ? ST_DONE : ST_WB;
        end else if (tmo_expired) begin
          state_d       = ST_FAULT;
          fault_cause_d = FC_TIMEOUT;
        end
      end
      ST_WB:    state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign issue    = (state_q == ST_CHECK) && (state_d == ST_REQ);
  assign load_ack = (state_q == ST_REQ) && mem_ack && !is_store_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      fault_cause_q    <= FC_NONE;
      is_store_q       <= 1'b0;
      rd_q             <= '0;
      addr_q           <= '0;
      key_q            <= '0;
      sdata_q          <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      address_mem_q    <= '0;
      write_data_mem_q <= '0;
    end else begin
      state_q       <= state_d;
      fault_cause_q <= fault_cause_d;
      if (accept) begin
        is_store_q <= req_is_store;
        rd_q       <= req_rd;
        addr_q     <= req_addr;
        key_q      <= req_key;
        sdata_q    <= store_data;
      end
      // mem_req tracks the next state so it rises with REQ and drops on the
      // edge that leaves REQ (ack or timeout).
      mem_req_q <= (state_d == ST_REQ);
      mem_we_q  <= (state_d == ST_REQ) && is_store_q;
      if (issue) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= is_store_q ? sdata_q : 32'd0;
      end
      // Loads to r0 are dropped: neither the index nor the data is updated.
      if (load_ack && (rd_q != 5'd0)) begin
        address_mem_q    <= rd_q;
        write_data_mem_q <= mem_rdata;
      end
    end
  end

  assign req_ready      = (state_q == ST_IDLE) && !rst;
  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign load_on        = (state_q == ST_WB) && (rd_q != 5'd0);
  assign address_mem    = address_mem_q;
  assign write_data_mem = write_data_mem_q;
  assign done           = (state_q == ST_DONE);
  assign fault          = (state_q == ST_FAULT);
  assign fault_cause    = fault_cause_q;

endmodule
